// File: rtl/exec_unit_pipelined_pkg.sv
// Opcode/func encodings, FSM states, ALU selectors and the flag bundle shared by the
// execute stage and its iterative multiply/divide unit.
package exec_unit_pipelined_pkg;

   localparam logic [6:0] OpcLoad   = 7'b0000011;
   localparam logic [6:0] OpcStore  = 7'b0100011;
   localparam logic [6:0] OpcOpImm  = 7'b0010011;
   localparam logic [6:0] OpcOp     = 7'b0110011;
   localparam logic [6:0] OpcBranch = 7'b1100011;

   localparam logic [6:0] F7Base   = 7'b0000000;
   localparam logic [6:0] F7Alt    = 7'b0100000;
   localparam logic [6:0] F7MulDiv = 7'b0000001;

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

   typedef enum logic [3:0] {
      AluAdd, AluSub, AluSll, AluSlt, AluSltu, AluXor, AluSrl, AluSra, AluOr, AluAnd
   } alu_op_e;

   typedef struct packed {
      logic mem_read;
      logic mem_write;
      logic mem_2_reg;
      logic alu_src;
      logic reg_write;
      logic branch;
      logic illegal;
   } flags_t;

   // alt picks SUB for func3 0 and SRA for func3 5; callers clear it where it does not apply.
   function automatic alu_op_e alu_op_from_f3(input logic [2:0] f3, input logic alt);
      alu_op_e op;
      case (f3)
         3'd0:    op = alt ? AluSub : AluAdd;
         3'd1:    op = AluSll;
         3'd2:    op = AluSlt;
         3'd3:    op = AluSltu;
         3'd4:    op = AluXor;
         3'd5:    op = alt ? AluSra : AluSrl;
         3'd6:    op = AluOr;
         default: op = AluAnd;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/exec_unit_pipelined_muldiv_iter.sv
// Iterative M-extension unit: radix-2 shift-add multiply and restoring divide on operand
// magnitudes, one step per cycle for XLEN steps, with sign fix-up on the way out.
module exec_unit_pipelined_muldiv_iter
   import exec_unit_pipelined_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            start_i,
   input  logic [2:0]      func3_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   output logic            busy_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o
);
   localparam int unsigned CntW = $clog2(XLEN + 1);

   logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d, d_q, d_d, a_q, a_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [2:0]        f3_q, f3_d;
   logic              busy_q, busy_d, neg_q, neg_d, dz_q, dz_d;
   logic              sa, sb, is_div;
   logic [XLEN-1:0]   ma, mb, dq;
   logic [2*XLEN-1:0] init_step, run_step, prod;

   // Divide: {hi,lo} is {remainder, dividend/quotient}. Multiply: {hi,lo} is the product with
   // the multiplier draining out of lo.
   function automatic logic [2*XLEN-1:0] step(input logic is_div_s, input logic [XLEN-1:0] hi,
                                              input logic [XLEN-1:0] lo,
                                              input logic [XLEN-1:0] d);
      logic [XLEN:0]     sh, trial, sum;
      logic [2*XLEN-1:0] nxt;
      sh    = {hi, lo[XLEN-1]};
      trial = sh - {1'b0, d};
      sum   = {1'b0, hi} + (lo[0] ? {1'b0, d} : '0);
      if (is_div_s) begin
         nxt = trial[XLEN] ? {sh[XLEN-1:0], lo[XLEN-2:0], 1'b0}
                           : {trial[XLEN-1:0], lo[XLEN-2:0], 1'b1};
      end else begin
         nxt = {sum[XLEN:1], sum[0], lo[XLEN-1:1]};
      end
      return nxt;
   endfunction

   always_comb begin
      is_div    = func3_i[2];
      sa        = a_i[XLEN-1] & (func3_i inside {3'd1, 3'd2, 3'd4, 3'd6});
      sb        = b_i[XLEN-1] & (func3_i inside {3'd1, 3'd4, 3'd6});
      ma        = sa ? -a_i : a_i;
      mb        = sb ? -b_i : b_i;
      init_step = step(is_div, '0, is_div ? ma : mb, is_div ? mb : ma);
      run_step  = step(f3_q[2], hi_q, lo_q, d_q);

      hi_d   = hi_q;
      lo_d   = lo_q;
      d_d    = d_q;
      a_d    = a_q;
      f3_d   = f3_q;
      neg_d  = neg_q;
      dz_d   = dz_q;
      cnt_d  = cnt_q;
      busy_d = busy_q;
      // The first step is folded into the start cycle so XLEN steps end one cycle earlier.
      if (start_i) begin
         {hi_d, lo_d} = init_step;
         d_d    = is_div ? mb : ma;
         a_d    = a_i;
         f3_d   = func3_i;
         dz_d   = (b_i == '0);
         neg_d  = (is_div & func3_i[1]) ? sa : (sa ^ sb);
         cnt_d  = CntW'(1);
         busy_d = 1'b1;
      end else if (busy_q) begin
         if (cnt_q == CntW'(XLEN)) begin
            busy_d = 1'b0;
         end else begin
            {hi_d, lo_d} = run_step;
            cnt_d = cnt_q + CntW'(1);
         end
      end
   end

   always_comb begin
      prod = {hi_q, lo_q};
      if (neg_q) prod = -prod;
      dq = f3_q[1] ? hi_q : lo_q;
      if (neg_q) dq = -dq;
      if (!f3_q[2]) begin
         result_o = (f3_q[1:0] == 2'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
      end else if (dz_q) begin
         result_o = f3_q[1] ? a_q : '1;
      end else begin
         result_o = dq;
      end
   end

   assign busy_o = busy_q;
   assign done_o = busy_q & (cnt_q == CntW'(XLEN));

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         hi_q   <= '0;
         lo_q   <= '0;
         d_q    <= '0;
         a_q    <= '0;
         f3_q   <= '0;
         neg_q  <= 1'b0;
         dz_q   <= 1'b0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
      end else begin
         hi_q   <= hi_d;
         lo_q   <= lo_d;
         d_q    <= d_d;
         a_q    <= a_d;
         f3_q   <= f3_d;
         neg_q  <= neg_d;
         dz_q   <= dz_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
      end
   end

endmodule

// File: rtl/exec_unit_pipelined.sv
// Registered RV32 execute stage with valid/ready on both sides; single-cycle ALU path and an
// iterative M-extension path.
module exec_unit_pipelined
   import exec_unit_pipelined_pkg::*;
#(
   parameter int unsigned XLEN      = 32,
   parameter int unsigned IMM_W     = 12,
   parameter bit          MULDIV_EN = 1'b1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [6:0]       opcode_i,
   input  logic [2:0]       func3_i,
   input  logic [6:0]       func7_i,
   input  logic [XLEN-1:0]  rs1_data_i,
   input  logic [XLEN-1:0]  rs2_data_i,
   input  logic [IMM_W-1:0] imm_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [XLEN-1:0]  result_o,
   output logic             zero_o,
   output logic             branch_o,
   output logic             mem_read_o,
   output logic             mem_write_o,
   output logic             mem_2_reg_o,
   output logic             alu_src_o,
   output logic             reg_write_o,
   output logic             illegal_o
);
   localparam int unsigned ShW = $clog2(XLEN);

   state_e          state_q, state_d;
   flags_t          flags_q, flags_d, dec, dec_out;
   logic [XLEN-1:0] result_q, result_d, imm_ext, op_b, alu_res, md_result;
   logic            zero_q, zero_d, legal, is_m, br_taken, accept, md_busy, md_done;
   alu_op_e         alu_op;
   logic [ShW-1:0]  shamt;

   always_comb begin
      dec     = '0;
      legal   = 1'b0;
      is_m    = 1'b0;
      alu_op  = AluAdd;
      imm_ext = {{(XLEN-IMM_W){imm_i[IMM_W-1]}}, imm_i};
      case (opcode_i)
         OpcLoad: begin
            legal = func3_i inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
            dec.mem_read  = 1'b1;
            dec.mem_2_reg = 1'b1;
            dec.alu_src   = 1'b1;
            dec.reg_write = 1'b1;
         end
         OpcStore: begin
            legal = func3_i inside {3'd0, 3'd1, 3'd2};
            dec.mem_write = 1'b1;
            dec.alu_src   = 1'b1;
         end
         OpcOp: begin
            dec.reg_write = 1'b1;
            if (func7_i == F7MulDiv) begin
               legal = MULDIV_EN;
               is_m  = MULDIV_EN;
            end else begin
               legal  = (func7_i == F7Base) ||
                        ((func7_i == F7Alt) && (func3_i == 3'd0 || func3_i == 3'd5));
               alu_op = alu_op_from_f3(func3_i, func7_i == F7Alt);
            end
         end
         OpcOpImm: begin
            dec.alu_src   = 1'b1;
            dec.reg_write = 1'b1;
            if (func3_i == 3'd1)      legal = (func7_i == F7Base);
            else if (func3_i == 3'd5) legal = (func7_i == F7Base) || (func7_i == F7Alt);
            else                      legal = 1'b1;
            alu_op = alu_op_from_f3(func3_i, (func3_i == 3'd5) && (func7_i == F7Alt));
         end
         OpcBranch: begin
            legal  = !(func3_i inside {3'd2, 3'd3});
            alu_op = AluSub;
         end
         default: legal = 1'b0;
      endcase
   end

   assign op_b  = dec.alu_src ? imm_ext : rs2_data_i;
   assign shamt = op_b[ShW-1:0];

   always_comb begin
      alu_res = '0;
      case (alu_op)
         AluAdd:  alu_res = rs1_data_i + op_b;
         AluSub:  alu_res = rs1_data_i - op_b;
         AluSll:  alu_res = rs1_data_i << shamt;
         AluSlt:  alu_res = {{(XLEN-1){1'b0}}, $signed(rs1_data_i) < $signed(op_b)};
         AluSltu: alu_res = {{(XLEN-1){1'b0}}, rs1_data_i < op_b};
         AluXor:  alu_res = rs1_data_i ^ op_b;
         AluSrl:  alu_res = rs1_data_i >> shamt;
         AluSra:  alu_res = $unsigned($signed(rs1_data_i) >>> shamt);
         AluOr:   alu_res = rs1_data_i | op_b;
         AluAnd:  alu_res = rs1_data_i & op_b;
         default: alu_res = '0;
      endcase
   end

   always_comb begin
      case (func3_i)
         3'd0:    br_taken = (rs1_data_i == rs2_data_i);
         3'd1:    br_taken = (rs1_data_i != rs2_data_i);
         3'd4:    br_taken = $signed(rs1_data_i) < $signed(rs2_data_i);
         3'd5:    br_taken = $signed(rs1_data_i) >= $signed(rs2_data_i);
         3'd6:    br_taken = rs1_data_i < rs2_data_i;
         3'd7:    br_taken = rs1_data_i >= rs2_data_i;
         default: br_taken = 1'b0;
      endcase
      dec_out        = dec;
      dec_out.branch = (opcode_i == OpcBranch) & br_taken;
      if (!legal) begin
         dec_out         = '0;
         dec_out.illegal = 1'b1;
      end
   end

   assign in_ready_o = !rst_i & ((state_q == StIdle) | ((state_q == StDone) & out_ready_i));
   assign accept     = in_valid_i & in_ready_o;

   exec_unit_pipelined_muldiv_iter #(
      .XLEN (XLEN)
   ) u_muldiv (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .start_i  (accept & is_m),
      .func3_i  (func3_i),
      .a_i      (rs1_data_i),
      .b_i      (rs2_data_i),
      .busy_o   (md_busy),
      .done_o   (md_done),
      .result_o (md_result)
   );

   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      flags_d  = flags_q;
      zero_d   = zero_q;
      case (state_q)
         StIdle: if (accept) state_d = is_m ? StBusy : StDone;
         StBusy: begin
            if (md_done) begin
               state_d           = StDone;
               result_d          = md_result;
               flags_d           = '0;
               flags_d.reg_write = 1'b1;
               zero_d            = (md_result == '0);
            end else if (!md_busy) begin
               state_d = StIdle;
            end
         end
         StDone: if (out_ready_i) state_d = accept ? (is_m ? StBusy : StDone) : StIdle;
         default: state_d = StIdle;
      endcase
      // M ops leave the previous outputs untouched until their own result lands.
      if (accept && !is_m) begin
         result_d = legal ? alu_res : '0;
         flags_d  = dec_out;
         zero_d   = legal && (alu_res == '0);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= StIdle;
         result_q <= '0;
         flags_q  <= '0;
         zero_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         flags_q  <= flags_d;
         zero_q   <= zero_d;
      end
   end

   assign out_valid_o = (state_q == StDone);
   assign result_o    = result_q;
   assign zero_o      = zero_q;
   assign branch_o    = flags_q.branch;
   assign mem_read_o  = flags_q.mem_read;
   assign mem_write_o = flags_q.mem_write;
   assign mem_2_reg_o = flags_q.mem_2_reg;
   assign alu_src_o   = flags_q.alu_src;
   assign reg_write_o = flags_q.reg_write;
   assign illegal_o   = flags_q.illegal;

endmodule

// File: tb/tb_exec_unit_pipelined.sv
// Directed and randomized checks of the execute stage against an arithmetic reference model.
module tb_exec_unit_pipelined;

   localparam logic [6:0] LOAD = 7'h03, STORE = 7'h23, OPIMM = 7'h13, OP = 7'h33, BR = 7'h63;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        in_valid_i, in_ready_o, out_valid_o, out_ready_i;
   logic [6:0]  opcode_i, func7_i;
   logic [2:0]  func3_i;
   logic [31:0] rs1_data_i, rs2_data_i, result_o;
   logic [11:0] imm_i;
   logic        zero_o, branch_o, mem_read_o, mem_write_o, mem_2_reg_o, alu_src_o;
   logic        reg_write_o, illegal_o;
   logic [6:0]  obs_fl;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk_i = ~clk_i;

   exec_unit_pipelined dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .opcode_i    (opcode_i),
      .func3_i     (func3_i),
      .func7_i     (func7_i),
      .rs1_data_i  (rs1_data_i),
      .rs2_data_i  (rs2_data_i),
      .imm_i       (imm_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .result_o    (result_o),
      .zero_o      (zero_o),
      .branch_o    (branch_o),
      .mem_read_o  (mem_read_o),
      .mem_write_o (mem_write_o),
      .mem_2_reg_o (mem_2_reg_o),
      .alu_src_o   (alu_src_o),
      .reg_write_o (reg_write_o),
      .illegal_o   (illegal_o)
   );

   // {mem_read, mem_write, mem_2_reg, alu_src, reg_write, branch, illegal}
   assign obs_fl = {mem_read_o, mem_write_o, mem_2_reg_o, alu_src_o, reg_write_o, branch_o,
                    illegal_o};

   typedef struct {
      logic [31:0] res;
      logic [6:0]  fl;
      logic        zero;
      bit          is_m;
   } exp_t;

   function automatic logic [31:0] alu_model(input logic [2:0] f3, input bit alt,
                                             input logic [31:0] a, input logic [31:0] b);
      int signed sa = a;
      int signed sb = b;
      case (f3)
         3'd0: return alt ? a - b : a + b;
         3'd1: return a << b[4:0];
         3'd2: return (sa < sb) ? 32'd1 : 32'd0;
         3'd3: return (a < b) ? 32'd1 : 32'd0;
         3'd4: return a ^ b;
         3'd5: return alt ? 32'(sa >>> b[4:0]) : a >> b[4:0];
         3'd6: return a | b;
         default: return a & b;
      endcase
   endfunction

   function automatic logic [31:0] md_model(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
      longint          as = $signed(a);
      longint          bs = $signed(b);
      longint          bz = {32'd0, b};
      longint unsigned au = {32'd0, a};
      longint unsigned bu = {32'd0, b};
      longint          p;
      longint unsigned pu;
      bit              ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (f3)
         3'd0: begin p = as * bs; return p[31:0]; end
         3'd1: begin p = as * bs; return p[63:32]; end
         3'd2: begin p = as * bz; return p[63:32]; end
         3'd3: begin pu = au * bu; return pu[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (ovf) return 32'h8000_0000;
            p = as / bs; return p[31:0];
         end
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (ovf) return 32'd0;
            p = as % bs; return p[31:0];
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic exp_t model(input logic [6:0] opc, input logic [2:0] f3,
                                  input logic [6:0] f7, input logic [31:0] a,
                                  input logic [31:0] b, input logic [11:0] imm);
      exp_t        e;
      bit          legal = 1'b1;
      logic [31:0] immx  = {{20{imm[11]}}, imm};
      bit          take;
      e.is_m = 1'b0;
      e.res  = 32'd0;
      e.fl   = 7'd0;
      case (opc)
         LOAD: begin
            legal = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
            e.res = a + immx; e.fl = 7'b1011100;
         end
         STORE: begin
            legal = (f3 <= 2);
            e.res = a + immx; e.fl = 7'b0101000;
         end
         OP: begin
            e.fl = 7'b0000100;
            if (f7 == 7'h01) begin
               e.is_m = 1'b1; e.res = md_model(f3, a, b);
            end else begin
               legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
               e.res = alu_model(f3, f7 == 7'h20, a, b);
            end
         end
         OPIMM: begin
            e.fl = 7'b0001100;
            if (f3 == 1) legal = (f7 == 7'h00);
            if (f3 == 5) legal = (f7 == 7'h00 || f7 == 7'h20);
            e.res = alu_model(f3, (f3 == 5) && (f7 == 7'h20), a, immx);
         end
         BR: begin
            legal = !(f3 == 2 || f3 == 3);
            case (f3)
               3'd0:    take = (a == b);
               3'd1:    take = (a != b);
               3'd4:    take = ($signed(a) < $signed(b));
               3'd5:    take = ($signed(a) >= $signed(b));
               3'd6:    take = (a < b);
               default: take = (a >= b);
            endcase
            e.res = a - b; e.fl = {5'd0, take, 1'b0};
         end
         default: legal = 1'b0;
      endcase
      if (!legal) begin
         e.res = 32'd0; e.fl = 7'b0000001; e.zero = 1'b0; e.is_m = 1'b0;
      end else begin
         e.zero = (e.res == 32'd0);
      end
      return e;
   endfunction

   task automatic check(input string tag, input string what, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s %s: observed %h expected %h", tag, what, obs, exp);
   endtask

   task automatic drive(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] a, input logic [31:0] b, input logic [11:0] imm);
      opcode_i = opc; func3_i = f3; func7_i = f7;
      rs1_data_i = a; rs2_data_i = b; imm_i = imm;
   endtask

   task automatic check_cleared(input string tag);
      check(tag, "out_valid", 32'(out_valid_o), 32'd0);
      check(tag, "in_ready", 32'(in_ready_o), 32'd1);
      check(tag, "result", result_o, 32'd0);
      check(tag, "flags", 32'(obs_fl), 32'd0);
      check(tag, "zero", 32'(zero_o), 32'd0);
   endtask

   // Called #1 after a rising edge; returns #1 after the edge where out_valid appears.
   task automatic do_op(input string tag, input logic [6:0] opc, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                        input logic [11:0] imm);
      exp_t e;
      int   cyc;
      e = model(opc, f3, f7, a, b, imm);
      drive(opc, f3, f7, a, b, imm);
      in_valid_i = 1'b1;
      @(negedge clk_i);
      check(tag, "in_ready", 32'(in_ready_o), 32'd1);
      @(posedge clk_i); #1;
      in_valid_i = 1'b0;
      cyc = 1;
      while (!out_valid_o && cyc < 40) begin
         @(posedge clk_i); #1;
         cyc++;
      end
      check(tag, "latency", cyc, e.is_m ? 32'd33 : 32'd1);
      check(tag, "result", result_o, e.res);
      check(tag, "flags", 32'(obs_fl), 32'(e.fl));
      check(tag, "zero", 32'(zero_o), 32'(e.zero));
   endtask

   initial begin
      logic [31:0] corner [5];
      logic [31:0] a, b;
      logic [6:0]  opc, f7;
      bit          seen;
      corner[0] = 32'd0;          corner[1] = 32'd1;          corner[2] = 32'hFFFF_FFFF;
      corner[3] = 32'h8000_0000;  corner[4] = 32'h7FFF_FFFF;

      rst_i = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b1;
      drive(7'd0, 3'd0, 7'd0, 32'd0, 32'd0, 12'd0);
      repeat (2) @(posedge clk_i);
      #3 rst_i = 1'b0;
      @(posedge clk_i); #1;
      check_cleared("reset");

      // Abort a DIV part-way through with reset.
      drive(OP, 3'd4, 7'h01, 32'd100, 32'd7, 12'd0);
      in_valid_i = 1'b1;
      @(posedge clk_i); #1;
      in_valid_i = 1'b0;
      repeat (10) @(posedge clk_i);
      #2 rst_i = 1'b1;
      @(posedge clk_i);
      #2 rst_i = 1'b0;
      @(posedge clk_i); #1;
      check_cleared("reset mid-DIV");
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk_i); #1;
         if (out_valid_o) seen = 1'b1;
      end
      check("reset mid-DIV", "stray out_valid", 32'(seen), 32'd0);

      do_op("LOAD", LOAD, 3'd2, 7'd0, 32'h1000, 32'd0, 12'h7FF);
      do_op("STORE", STORE, 3'd2, 7'd0, 32'h2000, 32'd0, 12'h800);

      // Back-to-back ADD then SUB with in_valid held.
      drive(OP, 3'd0, 7'h00, 32'd5, 32'd7, 12'd0);
      in_valid_i = 1'b1;
      @(posedge clk_i); #1;
      check("ADD b2b", "out_valid", 32'(out_valid_o), 32'd1);
      check("ADD b2b", "result", result_o, 32'h0000_000C);
      drive(OP, 3'd0, 7'h20, 32'd3, 32'd5, 12'd0);
      @(posedge clk_i); #1;
      in_valid_i = 1'b0;
      check("SUB b2b", "out_valid", 32'(out_valid_o), 32'd1);
      check("SUB b2b", "result", result_o, 32'hFFFF_FFFE);

      do_op("DIV ovf", OP, 3'd4, 7'h01, 32'h8000_0000, 32'hFFFF_FFFF, 12'd0);
      do_op("DIVU /0", OP, 3'd5, 7'h01, 32'd7, 32'd0, 12'd0);
      do_op("REM /0", OP, 3'd6, 7'h01, 32'd7, 32'd0, 12'd0);

      // BLT with the consumer stalled for three cycles while another op waits.
      drive(BR, 3'd4, 7'd0, 32'hFFFF_FFFF, 32'd1, 12'd0);
      in_valid_i = 1'b1;
      @(posedge clk_i); #1;
      drive(OP, 3'd0, 7'h00, 32'd10, 32'd20, 12'd0);
      out_ready_i = 1'b0;
      check("BLT", "out_valid", 32'(out_valid_o), 32'd1);
      check("BLT", "result", result_o, 32'hFFFF_FFFE);
      check("BLT", "flags", 32'(obs_fl), 32'b0000010);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk_i); #1;
         check("BLT hold", "out_valid", 32'(out_valid_o), 32'd1);
         check("BLT hold", "result", result_o, 32'hFFFF_FFFE);
         check("BLT hold", "flags", 32'(obs_fl), 32'b0000010);
         check("BLT hold", "in_ready", 32'(in_ready_o), 32'd0);
      end
      out_ready_i = 1'b1;
      @(posedge clk_i); #1;
      in_valid_i = 1'b0;
      check("ADD after stall", "result", result_o, 32'd30);
      check("ADD after stall", "flags", 32'(obs_fl), 32'b0000100);

      for (int n = 0; n < 80; n++) begin
         a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
         b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
         case ($urandom_range(0, 5))
            0:       opc = LOAD;
            1:       opc = STORE;
            2:       opc = OP;
            3:       opc = OPIMM;
            4:       opc = BR;
            default: opc = 7'($urandom);
         endcase
         case ($urandom_range(0, 3))
            0:       f7 = 7'h00;
            1:       f7 = 7'h20;
            2:       f7 = 7'h01;
            default: f7 = 7'($urandom);
         endcase
         do_op("rand", opc, 3'($urandom), f7, a, b, 12'($urandom));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
